spi_flash_boot_loader: RTL

- Upstream master for spi_flash_ip: after reset, or on a start pulse, it copies a block of SPI flash into an on-chip memory write port.
- Drives spi_flash_ip's register interface (wr_en/rd_en/addr/wdata/rdata) with a fixed one-word READ (0x03) transaction per word.
- Polls status, fetches the received word and writes it to memory.
- Reports done or timeout error to the system.

---
 rtl/spi_flash_boot_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_boot_loader.sv
// Boot copier: drives spi_flash_ip's register port to read flash one word at a time
// and writes each word into on-chip memory; reports done or poll-timeout error.
//
// state    | meaning
// IDLE     | waiting for start (or auto-start after reset)
// WR_CMD   | writing CMD = READ (0x03)
// WR_ADDR  | writing flash byte address
// WR_LEN   | writing LEN = 4 bytes
// WR_CTRL  | writing CTRL.start
// POLL_RD  | reading STATUS
// POLL_CHK | STATUS data on m_rdata; decide
// DATA_RD  | reading RXDATA
// DATA_CAP | RXDATA on m_rdata; capture into memory write
// MEM_WR   | memory write strobe high
// NEXT     | advance word count / pointer
// DONE     | copy complete
// ERR      | poll timeout on word mem_addr
module spi_flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE   = 24'h000000,
    parameter int          BOOT_WORDS   = 64,
    parameter int          MEM_AW       = 8,
    parameter int          POLL_TIMEOUT = 1024,
    parameter int          AUTO_START   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              boot_busy,
    output logic              boot_done,
    output logic              boot_err,
    output logic              m_wr_en,
    output logic              m_rd_en,
    output logic [7:0]        m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    localparam int WW = (MEM_AW > 16) ? MEM_AW : 16;
    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(BOOT_WORDS);
    localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_TIMEOUT);

    localparam logic [7:0] REG_CMD    = 8'h00;
    localparam logic [7:0] REG_ADDR   = 8'h04;
    localparam logic [7:0] REG_LEN    = 8'h08;
    localparam logic [7:0] REG_CTRL   = 8'h0C;
    localparam logic [7:0] REG_STATUS = 8'h10;
    localparam logic [7:0] REG_RXDATA = 8'h18;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CMD, S_WR_ADDR, S_WR_LEN, S_WR_CTRL, S_POLL_RD, S_POLL_CHK,
        S_DATA_RD, S_DATA_CAP, S_MEM_WR, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [WW-1:0]     word_cnt_q, word_cnt_d;
    logic [23:0]       ptr_q;
    logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
    logic              auto_q;
    logic              busy_q, done_q, err_q;
    logic              m_wr_en_q, m_rd_en_q;
    logic [7:0]        m_addr_q;
    logic [31:0]       m_wdata_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    assign word_cnt_d = word_cnt_q + 1'b1;
    assign poll_cnt_d = poll_cnt_q + 1'b1;

    // Each branch loads the strobes for the state it enters, so a strobe is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            ptr_q       <= FLASH_BASE;
            poll_cnt_q  <= '0;
            auto_q      <= (AUTO_START != 0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_wr_en_q   <= 1'b0;
            m_rd_en_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            m_wr_en_q   <= 1'b0;
            m_rd_en_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start || auto_q) begin
                        auto_q     <= 1'b0;
                        word_cnt_q <= '0;
                        ptr_q      <= FLASH_BASE;
                        poll_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= S_WR_CMD;
                        m_wr_en_q  <= 1'b1;
                        m_addr_q   <= REG_CMD;
                        m_wdata_q  <= 32'h0000_0003;
                    end
                end
                S_WR_CMD: begin
                    state_q   <= S_WR_ADDR;
                    m_wr_en_q <= 1'b1;
                    m_addr_q  <= REG_ADDR;
                    m_wdata_q <= {8'h00, ptr_q};
                end
                S_WR_ADDR: begin
                    state_q   <= S_WR_LEN;
                    m_wr_en_q <= 1'b1;
                    m_addr_q  <= REG_LEN;
                    m_wdata_q <= 32'd4;
                end
                S_WR_LEN: begin
                    state_q   <= S_WR_CTRL;
                    m_wr_en_q <= 1'b1;
                    m_addr_q  <= REG_CTRL;
                    m_wdata_q <= 32'd1;
                end
                S_WR_CTRL: begin
                    state_q   <= S_POLL_RD;
                    m_rd_en_q <= 1'b1;
                    m_addr_q  <= REG_STATUS;
                end
                S_POLL_RD: begin
                    state_q <= S_POLL_CHK;
                end
                S_POLL_CHK: begin
                    if (m_rdata[1] && !m_rdata[0]) begin
                        state_q   <= S_DATA_RD;
                        m_rd_en_q <= 1'b1;
                        m_addr_q  <= REG_RXDATA;
                    end else if (poll_cnt_d == POLL_MAX) begin
                        poll_cnt_q <= poll_cnt_d;
                        state_q    <= S_ERR;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        mem_addr_q <= word_cnt_q[MEM_AW-1:0];
                    end else begin
                        poll_cnt_q <= poll_cnt_d;
                        state_q    <= S_POLL_RD;
                        m_rd_en_q  <= 1'b1;
                        m_addr_q   <= REG_STATUS;
                    end
                end
                S_DATA_RD: begin
                    state_q <= S_DATA_CAP;
                end
                S_DATA_CAP: begin
                    state_q     <= S_MEM_WR;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= word_cnt_q[MEM_AW-1:0];
                    mem_wdata_q <= m_rdata;
                end
                S_MEM_WR: begin
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    word_cnt_q <= word_cnt_d;
                    ptr_q      <= ptr_q + 24'd4;
                    poll_cnt_q <= '0;
                    if (word_cnt_d == LAST_WORD) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= S_WR_CMD;
                        m_wr_en_q <= 1'b1;
                        m_addr_q  <= REG_CMD;
                        m_wdata_q <= 32'h0000_0003;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign boot_busy = busy_q;
    assign boot_done = done_q;
    assign boot_err  = err_q;
    assign m_wr_en   = m_wr_en_q;
    assign m_rd_en   = m_rd_en_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
